// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the 32-slice RV32I datapath: fetch, decode, execute,
// memory and write-back, driving all per-slice selects as registered outputs.
module rv32i_ctrl_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            cmp_eq,
    input  logic            cmp_lt,
    output logic            pc_we,
    output logic            pc_mux_sel,
    output logic [31:0]     pc_reset_value,
    output logic [XLEN-1:0] rs1_sel,
    output logic [XLEN-1:0] rs2_sel,
    output logic [XLEN-1:0] rd_sel,
    output logic [2:0]      rd_mux_sel,
    output logic [2:0]      mem_mux_sel,
    output logic [1:0]      alu_op,
    output logic            alu_inv_rs2,
    output logic            alu_cin,
    output logic            alu_mux1_sel,
    output logic            alu_mux2_sel,
    output logic            shift_dir,
    output logic            shift_arith,
    output logic            cmp_unsigned,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    typedef enum logic [2:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LOAD, C_STORE
    } cls_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t          state_r;
    cls_t            cls_r;
    cls_t            dec_cls_s;
    logic [31:0]     ir_r;
    logic [4:0]      rd_idx_r;
    logic [2:0]      f3_r;
    logic            pc_we_r;
    logic [6:0]      opcode_s;
    logic [2:0]      f3_s;
    logic            dec_legal_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_rd_mux_s;
    logic [1:0]      dec_alu_op_s;
    logic            dec_inv_s;
    logic            dec_mux1_s;
    logic            dec_mux2_s;
    logic            dec_sdir_s;
    logic            dec_sarith_s;
    logic            dec_cuns_s;
    logic            br_taken_s;
    logic            is_jump_s;
    logic [XLEN-1:0] wb_rd_sel_s;

    function automatic logic [XLEN-1:0] onehot(input logic [4:0] idx);
        onehot = {{(XLEN-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign opcode_s       = ir_r[6:0];
    assign f3_s           = ir_r[14:12];
    assign pc_reset_value = RESET_PC;
    // The reset state holds pc_we high once rst releases, so the datapath loads RESET_PC on the RST->FETCH edge.
    assign pc_we          = pc_we_r | (rst & (state_r == ST_RST));

    // Instruction decode from the latched IR: class, immediate and execute-phase controls.
    always_comb begin
        dec_cls_s    = C_ALU;
        dec_legal_s  = 1'b1;
        dec_imm_s    = '0;
        dec_rd_mux_s = 3'b000;
        dec_alu_op_s = 2'b00;
        dec_inv_s    = 1'b0;
        dec_mux1_s   = 1'b0;
        dec_mux2_s   = 1'b0;
        dec_sdir_s   = 1'b0;
        dec_sarith_s = 1'b0;
        dec_cuns_s   = 1'b0;
        case (opcode_s)
            OP_LUI: begin
                dec_cls_s    = C_LUI;
                dec_imm_s    = {ir_r[31:12], 12'h000};
                dec_rd_mux_s = 3'b011;
            end
            OP_AUIPC: begin
                dec_cls_s  = C_AUIPC;
                dec_imm_s  = {ir_r[31:12], 12'h000};
                dec_mux1_s = 1'b1;
                dec_mux2_s = 1'b1;
            end
            OP_JAL: begin
                dec_cls_s    = C_JAL;
                dec_imm_s    = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
                dec_rd_mux_s = 3'b100;
                dec_mux1_s   = 1'b1;
                dec_mux2_s   = 1'b1;
            end
            OP_JALR: begin
                dec_cls_s    = C_JALR;
                dec_imm_s    = {{20{ir_r[31]}}, ir_r[31:20]};
                dec_rd_mux_s = 3'b100;
                dec_mux2_s   = 1'b1;
            end
            OP_BRANCH: begin
                dec_cls_s  = C_BR;
                dec_imm_s  = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
                dec_inv_s  = 1'b1;
                dec_cuns_s = f3_s[1];
            end
            OP_LOAD: begin
                dec_cls_s    = C_LOAD;
                dec_imm_s    = {{20{ir_r[31]}}, ir_r[31:20]};
                dec_rd_mux_s = 3'b101;
                dec_mux2_s   = 1'b1;
            end
            OP_STORE: begin
                dec_cls_s  = C_STORE;
                dec_imm_s  = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
                dec_mux2_s = 1'b1;
            end
            OP_IMM, OP_REG: begin
                dec_cls_s  = C_ALU;
                dec_mux2_s = (opcode_s == OP_IMM);
                if (opcode_s == OP_IMM) begin
                    dec_imm_s = {{20{ir_r[31]}}, ir_r[31:20]};
                end else begin
                    dec_imm_s = '0;
                end
                case (f3_s)
                    3'b000: dec_inv_s = (opcode_s == OP_REG) & ir_r[30];
                    3'b001: dec_rd_mux_s = 3'b001;
                    3'b010: begin
                        dec_rd_mux_s = 3'b010;
                        dec_inv_s    = 1'b1;
                    end
                    3'b011: begin
                        dec_rd_mux_s = 3'b010;
                        dec_inv_s    = 1'b1;
                        dec_cuns_s   = 1'b1;
                    end
                    3'b100: dec_alu_op_s = 2'b01;
                    3'b101: begin
                        dec_rd_mux_s = 3'b001;
                        dec_sdir_s   = 1'b1;
                        dec_sarith_s = ir_r[30];
                    end
                    3'b110: dec_alu_op_s = 2'b10;
                    3'b111: dec_alu_op_s = 2'b11;
                    default: dec_alu_op_s = 2'b00;
                endcase
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Branch condition from the MSB-slice compare chain, selected by the branch funct3.
    always_comb begin
        case (f3_r)
            3'b000:         br_taken_s = cmp_eq;
            3'b001:         br_taken_s = ~cmp_eq;
            3'b100, 3'b110: br_taken_s = cmp_lt;
            3'b101, 3'b111: br_taken_s = ~cmp_lt;
            default:        br_taken_s = 1'b0;
        endcase
    end

    // Write-back strobe: suppressed for x0 and for classes that produce no register result.
    always_comb begin
        is_jump_s = (cls_r == C_JAL) | (cls_r == C_JALR);
        if ((rd_idx_r == 5'd0) || (cls_r == C_BR) || (cls_r == C_STORE)) begin
            wb_rd_sel_s = '0;
        end else begin
            wb_rd_sel_s = onehot(rd_idx_r);
        end
    end

    // Sequencer state and all registered datapath controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_RST;
            cls_r        <= C_ALU;
            ir_r         <= 32'h0000_0000;
            rd_idx_r     <= 5'd0;
            f3_r         <= 3'b000;
            pc_we_r      <= 1'b0;
            imem_req     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            pc_mux_sel   <= 1'b0;
            rs1_sel      <= '0;
            rs2_sel      <= '0;
            rd_sel       <= '0;
            rd_mux_sel   <= 3'b000;
            mem_mux_sel  <= 3'b000;
            alu_op       <= 2'b00;
            alu_inv_rs2  <= 1'b0;
            alu_cin      <= 1'b0;
            alu_mux1_sel <= 1'b0;
            alu_mux2_sel <= 1'b0;
            shift_dir    <= 1'b0;
            shift_arith  <= 1'b0;
            cmp_unsigned <= 1'b0;
            imm          <= '0;
            illegal      <= 1'b0;
        end else begin
            rd_sel     <= '0;
            pc_we_r    <= 1'b0;
            pc_mux_sel <= 1'b0;
            case (state_r)
                ST_RST: begin
                    imem_req <= 1'b1;
                    state_r  <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_r     <= imem_rdata;
                        imem_req <= 1'b0;
                        state_r  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!dec_legal_s) begin
                        illegal <= 1'b1;
                        state_r <= ST_HALT;
                    end else begin
                        cls_r        <= dec_cls_s;
                        rd_idx_r     <= ir_r[11:7];
                        f3_r         <= f3_s;
                        rs1_sel      <= onehot(ir_r[19:15]);
                        rs2_sel      <= onehot(ir_r[24:20]);
                        imm          <= dec_imm_s;
                        rd_mux_sel   <= dec_rd_mux_s;
                        mem_mux_sel  <= (dec_cls_s == C_LOAD) ? f3_s : 3'b000;
                        alu_op       <= dec_alu_op_s;
                        alu_inv_rs2  <= dec_inv_s;
                        alu_cin      <= dec_inv_s;
                        alu_mux1_sel <= dec_mux1_s;
                        alu_mux2_sel <= dec_mux2_s;
                        shift_dir    <= dec_sdir_s;
                        shift_arith  <= dec_sarith_s;
                        cmp_unsigned <= dec_cuns_s;
                        state_r      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if ((cls_r == C_LOAD) || (cls_r == C_STORE)) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= (cls_r == C_STORE);
                        alu_op       <= 2'b00;
                        alu_inv_rs2  <= 1'b0;
                        alu_cin      <= 1'b0;
                        alu_mux1_sel <= 1'b0;
                        alu_mux2_sel <= 1'b1;
                        state_r      <= ST_MEM;
                    end else begin
                        rd_sel     <= wb_rd_sel_s;
                        pc_we_r    <= 1'b1;
                        pc_mux_sel <= is_jump_s | ((cls_r == C_BR) & br_taken_s);
                        // Redirect targets are computed in WB as base + imm; JALR uses rs1 as base.
                        if (is_jump_s || (cls_r == C_BR)) begin
                            alu_op       <= 2'b00;
                            alu_inv_rs2  <= 1'b0;
                            alu_cin      <= 1'b0;
                            alu_mux1_sel <= (cls_r != C_JALR);
                            alu_mux2_sel <= 1'b1;
                        end
                        if (cls_r == C_JALR) begin
                            imm[0] <= 1'b0;
                        end
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rd_sel   <= wb_rd_sel_s;
                        pc_we_r  <= 1'b1;
                        state_r  <= ST_WB;
                    end
                end
                ST_WB: begin
                    imem_req <= 1'b1;
                    state_r  <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Scoreboard bench for rv32i_ctrl_fsm: per-instruction expectations are queued when the
// instruction is issued and compared when the controller reaches write-back.
`timescale 1ns/1ps
module tb_rv32i_ctrl_fsm;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, cmp_eq, cmp_lt;
    logic [31:0] imem_rdata, pc_reset_value, rs1_sel, rs2_sel, rd_sel, imm;
    logic        pc_we, pc_mux_sel, alu_inv_rs2, alu_cin, alu_mux1_sel, alu_mux2_sel;
    logic        shift_dir, shift_arith, cmp_unsigned, illegal;
    logic [2:0]  rd_mux_sel, mem_mux_sel;
    logic [1:0]  alu_op;

    always #5 clk = ~clk;

    rv32i_ctrl_fsm #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .pc_we(pc_we), .pc_mux_sel(pc_mux_sel), .pc_reset_value(pc_reset_value),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
        .rd_mux_sel(rd_mux_sel), .mem_mux_sel(mem_mux_sel),
        .alu_op(alu_op), .alu_inv_rs2(alu_inv_rs2), .alu_cin(alu_cin),
        .alu_mux1_sel(alu_mux1_sel), .alu_mux2_sel(alu_mux2_sel),
        .shift_dir(shift_dir), .shift_arith(shift_arith), .cmp_unsigned(cmp_unsigned),
        .imm(imm), .illegal(illegal)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rd_sel;
        logic [2:0]  rd_mux;
        logic        pc_mux;
        int          n_rd;
        int          n_dreq;
        logic        we;
        logic [2:0]  mem_mux;
        logic [31:0] imm;
        logic        inv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one instruction with zero-wait imem and dwait dmem wait cycles, then score its WB.
    task automatic run_instr(input string name, input logic [31:0] instr, input int dwait,
                             input logic eq, input logic lt, input int e_cyc,
                             input logic [31:0] e_rd, input logic [2:0] e_rmux, input logic e_pmux,
                             input int e_nrd, input int e_ndreq, input logic e_we,
                             input logic [2:0] e_mmux, input logic [31:0] e_imm, input logic e_inv);
        exp_t e;
        exp_t x;
        int   cyc, n_rd, n_dreq, rd_cyc, ack_cyc;
        logic we_seen, inv_seen;
        bit   done;
        e.name = name; e.cyc = e_cyc; e.rd_sel = e_rd; e.rd_mux = e_rmux; e.pc_mux = e_pmux;
        e.n_rd = e_nrd; e.n_dreq = e_ndreq; e.we = e_we; e.mem_mux = e_mmux; e.imm = e_imm;
        e.inv = e_inv;
        sb_q.push_back(e);
        cyc = 0; n_rd = 0; n_dreq = 0; rd_cyc = 0; ack_cyc = 0;
        we_seen = 1'b0; inv_seen = 1'b0; done = 1'b0;
        cmp_eq = eq; cmp_lt = lt; imem_rdata = instr;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rd_sel != 32'h0) begin
                n_rd++;
                rd_cyc = cyc;
            end
            if (dmem_req) begin
                n_dreq++;
                we_seen = we_seen | dmem_we;
            end
            if (cyc == 3) inv_seen = alu_inv_rs2 & alu_cin;
            imem_ack = imem_req;
            dmem_ack = dmem_req && (n_dreq > dwait);
            if (dmem_ack) ack_cyc = cyc;
            if (pc_we) begin
                done = 1'b1;
                x = sb_q.pop_front();
                check_val({x.name, ".wb_cyc"}, 32'(cyc), 32'(x.cyc));
                check_val({x.name, ".rd_sel"}, rd_sel, x.rd_sel);
                check_val({x.name, ".rd_mux"}, 32'(rd_mux_sel), 32'(x.rd_mux));
                check_val({x.name, ".pc_mux"}, 32'(pc_mux_sel), 32'(x.pc_mux));
                check_val({x.name, ".mem_mux"}, 32'(mem_mux_sel), 32'(x.mem_mux));
                check_val({x.name, ".imm"}, imm, x.imm);
            end
        end
        if (!done) begin
            check_val({name, ".timeout"}, 32'(cyc), 32'd0);
            if (sb_q.size() > 0) x = sb_q.pop_front();
        end else begin
            check_val({x.name, ".n_rd"}, 32'(n_rd), 32'(x.n_rd));
            check_val({x.name, ".n_dreq"}, 32'(n_dreq), 32'(x.n_dreq));
            check_val({x.name, ".dmem_we"}, 32'(we_seen), 32'(x.we));
            check_val({x.name, ".exec_inv"}, 32'(inv_seen), 32'(x.inv));
            if (x.n_rd > 0) check_val({x.name, ".rd_cyc"}, 32'(rd_cyc), 32'(x.cyc));
            if (x.n_dreq > 0) check_val({x.name, ".wb_after_ack"}, 32'(cyc), 32'(ack_cyc + 1));
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    initial begin
        int   cnt_req, cnt_pcwe, cnt_rd, nd;
        bit   hit;
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0;
        cmp_eq = 1'b0; cmp_lt = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.imem_req", 32'(imem_req), 32'd0);
        check_val("rst.dmem_req", 32'(dmem_req), 32'd0);
        check_val("rst.pc_we", 32'(pc_we), 32'd0);
        check_val("rst.rd_sel", rd_sel, 32'h0);
        check_val("rst.illegal", 32'(illegal), 32'd0);
        check_val("rst.pc_reset_value", pc_reset_value, RESET_PC);
        rst = 1'b1;
        #1;
        check_val("boot.pc_we", 32'(pc_we), 32'd1);
        check_val("boot.imem_req", 32'(imem_req), 32'd0);

        //        name      instr         dw eq lt cyc rd_sel  rmux    pm nrd nd we mmux    imm            inv
        run_instr("addi",   32'h00500093, 0, 0, 0, 4, 32'h2,  3'b000, 0, 1, 0, 0, 3'b000, 32'd5,         0);
        run_instr("lw",     32'h0040A103, 3, 0, 0, 8, 32'h4,  3'b101, 0, 1, 4, 0, 3'b010, 32'd4,         0);
        run_instr("sw",     32'h0020A423, 1, 0, 0, 6, 32'h0,  3'b000, 0, 0, 2, 1, 3'b000, 32'd8,         0);
        run_instr("beq_t",  32'hFE108CE3, 0, 1, 0, 4, 32'h0,  3'b000, 1, 0, 0, 0, 3'b000, 32'hFFFF_FFF8, 1);
        run_instr("beq_nt", 32'hFE108CE3, 0, 0, 0, 4, 32'h0,  3'b000, 0, 0, 0, 0, 3'b000, 32'hFFFF_FFF8, 1);
        run_instr("add_x0", 32'h00208033, 0, 0, 0, 4, 32'h0,  3'b000, 0, 0, 0, 0, 3'b000, 32'h0,         0);
        run_instr("jal",    32'h010000EF, 0, 0, 0, 4, 32'h2,  3'b100, 1, 1, 0, 0, 3'b000, 32'd16,        0);
        run_instr("lui",    32'h123451B7, 0, 0, 0, 4, 32'h8,  3'b011, 0, 1, 0, 0, 3'b000, 32'h1234_5000, 0);
        run_instr("sub",    32'h402081B3, 0, 0, 0, 4, 32'h8,  3'b000, 0, 1, 0, 0, 3'b000, 32'h0,         1);

        // Illegal opcode: controller halts, ignores stray acks and stays quiet until reset.
        imem_rdata = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack = imem_req;
        end
        check_val("ill.illegal", 32'(illegal), 32'd1);
        cnt_req = 0; cnt_pcwe = 0; cnt_rd = 0;
        imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) cnt_req++;
            if (pc_we) cnt_pcwe++;
            if (rd_sel != 32'h0) cnt_rd++;
        end
        imem_ack = 1'b0;
        check_val("ill.no_req", 32'(cnt_req), 32'd0);
        check_val("ill.no_pc_we", 32'(cnt_pcwe), 32'd0);
        check_val("ill.no_rd_sel", 32'(cnt_rd), 32'd0);
        rst = 1'b0;
        #1;
        check_val("ill.cleared", 32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("ill.boot_pc_we", 32'(pc_we), 32'd1);
        run_instr("addi2",  32'h00500093, 0, 0, 0, 4, 32'h2,  3'b000, 0, 1, 0, 0, 3'b000, 32'd5,         0);

        // Reset pulled while a store is waiting for its ack.
        imem_rdata = 32'h0020A423;
        nd = 0; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            if (dmem_req) nd++;
            if (nd == 2) hit = 1'b1;
        end
        check_val("srst.store_pending", 32'(hit), 32'd1);
        check_val("srst.dmem_we_pre", 32'(dmem_we), 32'd1);
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        check_val("srst.dmem_req", 32'(dmem_req), 32'd0);
        check_val("srst.dmem_we", 32'(dmem_we), 32'd0);
        check_val("srst.pc_we", 32'(pc_we), 32'd0);
        dmem_ack = 1'b1;
        cnt_rd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rd_sel != 32'h0) cnt_rd++;
        end
        dmem_ack = 1'b0;
        check_val("srst.no_rd_sel", 32'(cnt_rd), 32'd0);
        rst = 1'b1;
        #1;
        check_val("srst.boot_pc_we", 32'(pc_we), 32'd1);
        check_val("srst.pc_reset_value", pc_reset_value, RESET_PC);
        run_instr("addi3",  32'h00500093, 0, 0, 0, 4, 32'h2,  3'b000, 0, 1, 0, 0, 3'b000, 32'd5,         0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
